page_sequencer: RTL and testbench
=================================

Name: page_sequencer

Overview:
- Top-level screen-flow controller for the UI pages: cover, game and game-over.
- Selects which page's pixel colour reaches the VGA output and gates the game logic.
- Sequences frame-timed fade-out/fade-in transitions between pages.
- Sits between the page colour generators (cover page, game renderer, game-over page) and the VGA colour output register.

Parameters:
- FRAMES_PER_STEP, 2: frame_clk rising edges per fade level step (>=1).
- GAMEOVER_FRAMES, 300: frames the game-over page is held before auto-return to cover (>=1).

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset_n  input  1  asynchronous, active-low reset.
- frame_clk  input  1  VGA vertical sync; synchronous to Clk; rising edge = frame tick.
- start_key  input  1  start/confirm key, level, active-high.
- game_over  input  1  level from game logic, active-high.
- color_cover  input  24  cover page pixel colour, RGB 8:8:8.
- color_game  input  24  game page pixel colour.
- color_over  input  24  game-over page pixel colour.
- color_out  output  24  final pixel colour to VGA.
- page  output  2  current page: 0 cover, 1 game, 2 game-over (3 never driven).
- fade_level  output  4  brightness, 0 (black) .. 15 (full).
- game_run  output  1  high only while the game page is stable; enables game logic.
- busy  output  1  high during any fade.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state=S_COVER, page=0, target=0, fade_level=15.
  - color_out=0, game_run=0, busy=0.
  - frame step counter=0, game-over frame counter=0.
  - frame_clk_prev=1 and start_prev=1, so a level held through reset release is not an edge.
- Edges: frame_tick = frame_clk & ~frame_clk_prev; start_press = start_key & ~start_prev. Both previous-value registers update every Clk.
- States:
  - S_COVER: start_press -> S_FADE_OUT, target=1.
  - S_GAME: game_run=1. game_over high -> S_FADE_OUT, target=2. start_press is ignored.
  - S_OVER: counts frame_tick. At GAMEOVER_FRAMES ticks, or on start_press, -> S_FADE_OUT, target=0. If both occur in the same cycle, only one transition is taken. The counter clears on entry.
  - S_FADE_OUT: busy=1. Every FRAMES_PER_STEP frame_ticks, fade_level decrements. On the step that would go below 0 (level already 0): page<=target, -> S_FADE_IN, step counter cleared.
  - S_FADE_IN: busy=1. Every FRAMES_PER_STEP frame_ticks, fade_level increments. On the step at level 15: -> S_COVER, S_GAME or S_OVER per page.
- All key and game_over inputs are ignored while busy.
- Full fade, with FRAMES_PER_STEP=F: 16*F frame ticks out plus 16*F frame ticks in.
- game_run drops on the same Clk that S_GAME exits. It rises on the Clk S_GAME is entered.
- Colour datapath, registered with 1 Clk latency:
  - Source selected by the page value in the same cycle; page 3 selects 0.
  - Per channel: out = (fade_level==0) ? 0 : (c*(fade_level+1))>>4.
  - 8x5-bit product, 13-bit intermediate, truncated to 8 bits.
  - fade_level=15 passes colour unchanged.
- Reset mid-fade returns immediately to the full-brightness cover page.

Optional Feature:
- PAGE_FADE_EN defined: fades as above.
- PAGE_FADE_EN undefined:
  - S_FADE_OUT and S_FADE_IN each last exactly one Clk. page switches in that single cycle.
  - busy is high for 2 Clk per transition.
  - fade_level is held at 15.
  - Colour scaling logic is removed; color_out = selected colour, registered.

Test Plan:
- Reset release with start_key held high -> stays S_COVER, page=0. color_out = color_cover one Clk later (e.g. in 24'h6B83FE -> out 24'h6B83FE).
- start_key pulse, F=2 -> fade_level 15 -> 0 over 32 frame ticks. Then page=1, rising to 15 over 32 more ticks. game_run=1 only after level 15; busy low at the same time.
- At fade_level=7, color_cover=24'hF7F6D8 -> color_out=24'h7B7B6C; at fade_level=0 -> 24'h000000.
- In S_GAME, raise game_over -> game_run=0 next Clk, fade to page=2. After 300 frame ticks with no key -> fade back to page=0.
- In S_OVER, start_press on the same cycle as the 300th tick -> exactly one transition to page 0. Presses during a fade do not alter target.
- Reset_n asserted mid-fade (fade_level=5, page=1) -> page=0, fade_level=15, busy=0, color_out=0 asynchronously. Rebuild without PAGE_FADE_EN -> busy high 2 Clk, fade_level constant 15.

Source files
------------

// File: rtl/page_sequencer.sv
// page_sequencer -- screen-flow controller for the cover, game and game-over
// pages. Chooses which page colour reaches the VGA output register, enables
// the game logic only while the game page is stable, and sequences
// frame-paced fade-out/fade-in transitions between pages.
//
// Build option: define PAGE_FADE_EN for the frame-paced brightness fades.
// Without it every page change is a two-cycle swap at full brightness and
// the colour scaling datapath is not built.
module page_sequencer #(
   parameter int FRAMES_PER_STEP = 2,   // frame ticks per brightness step (>=1)
   parameter int GAMEOVER_FRAMES = 300  // frames the game-over page is held (>=1)
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        frame_clk,
   input  logic        start_key,
   input  logic        game_over,
   input  logic [23:0] color_cover,
   input  logic [23:0] color_game,
   input  logic [23:0] color_over,
   output logic [23:0] color_out,
   output logic [1:0]  page,
   output logic [3:0]  fade_level,
   output logic        game_run,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_COVER,
      S_GAME,
      S_OVER,
      S_FADE_OUT,
      S_FADE_IN
   } state_t;

   localparam logic [1:0] PAGE_COVER = 2'd0;
   localparam logic [1:0] PAGE_GAME  = 2'd1;
   localparam logic [1:0] PAGE_OVER  = 2'd2;

   localparam logic [3:0] LEVEL_FULL = 4'd15;
   localparam logic [3:0] LEVEL_DARK = 4'd0;

   // Game-over hold counter: counts frame ticks 0 .. GAMEOVER_FRAMES-1.
   localparam int             OCW       = $clog2(GAMEOVER_FRAMES + 1);
   localparam logic [OCW-1:0] OVER_LAST = OCW'(GAMEOVER_FRAMES - 1);

`ifdef PAGE_FADE_EN
   // Fade pacing counter: counts frame ticks 0 .. FRAMES_PER_STEP-1.
   localparam int             SCW       = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [SCW-1:0] STEP_LAST = SCW'(FRAMES_PER_STEP - 1);
`endif

   state_t         state_q, state_d;
   logic [1:0]     page_q, page_d;
   logic [1:0]     target_q, target_d;
   logic [3:0]     fade_level_q, fade_level_d;
   logic [23:0]    color_out_q, color_out_d;
   logic           game_run_q, game_run_d;
   logic           busy_q, busy_d;
   logic [OCW-1:0] over_cnt_q, over_cnt_d;
   logic           frame_clk_prev_q, start_prev_q;
`ifdef PAGE_FADE_EN
   logic [SCW-1:0] step_cnt_q, step_cnt_d;
`endif

   logic           frame_tick;
   logic           start_press;
   logic [23:0]    color_sel;

   // Rising-edge detection. The previous-value registers come out of reset
   // high, so a level already asserted at reset release is not an edge.
   assign frame_tick  = frame_clk & ~frame_clk_prev_q;
   assign start_press = start_key & ~start_prev_q;

   // Stable state reached once the fade-in completes on a given page.
   function automatic state_t state_for_page(input logic [1:0] p);
      case (p)
         PAGE_GAME: return S_GAME;
         PAGE_OVER: return S_OVER;
         default:   return S_COVER;
      endcase
   endfunction

`ifdef PAGE_FADE_EN
   // One channel scaled by (level+1)/16: 8x5-bit product, shifted, truncated.
   function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [3:0] lvl);
      logic [12:0] prod;
      prod = 13'(c) * (13'(lvl) + 13'd1);
      return 8'(prod >> 4);
   endfunction
`endif

   // Screen-flow next state: page selection, fade stepping and frame counters.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d      = state_q;
      page_d       = page_q;
      target_d     = target_q;
      fade_level_d = fade_level_q;
      over_cnt_d   = '0;
`ifdef PAGE_FADE_EN
      step_cnt_d   = '0;
`endif

      case (state_q)
         S_COVER: begin
            if (start_press) begin
               state_d  = S_FADE_OUT;
               target_d = PAGE_GAME;
            end
         end

         S_GAME: begin
            // Start presses are deliberately ignored while playing.
            if (game_over) begin
               state_d  = S_FADE_OUT;
               target_d = PAGE_OVER;
            end
         end

         S_OVER: begin
            // Timeout and key press share one exit, so a coincidence is a
            // single transition.
            if (start_press || (frame_tick && (over_cnt_q == OVER_LAST))) begin
               state_d  = S_FADE_OUT;
               target_d = PAGE_COVER;
            end else if (frame_tick) begin
               over_cnt_d = over_cnt_q + 1'b1;
            end else begin
               over_cnt_d = over_cnt_q;
            end
         end

         S_FADE_OUT: begin
`ifdef PAGE_FADE_EN
            step_cnt_d = step_cnt_q;
            if (frame_tick) begin
               if (step_cnt_q == STEP_LAST) begin
                  step_cnt_d = '0;
                  if (fade_level_q == LEVEL_DARK) begin
                     // The screen is black: swap the page and start fading in.
                     page_d  = target_q;
                     state_d = S_FADE_IN;
                  end else begin
                     fade_level_d = fade_level_q - 4'd1;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + 1'b1;
               end
            end
`else
            page_d  = target_q;
            state_d = S_FADE_IN;
`endif
         end

         S_FADE_IN: begin
`ifdef PAGE_FADE_EN
            step_cnt_d = step_cnt_q;
            if (frame_tick) begin
               if (step_cnt_q == STEP_LAST) begin
                  step_cnt_d = '0;
                  if (fade_level_q == LEVEL_FULL) begin
                     state_d = state_for_page(page_q);
                  end else begin
                     fade_level_d = fade_level_q + 4'd1;
                  end
               end else begin
                  step_cnt_d = step_cnt_q + 1'b1;
               end
            end
`else
            state_d = state_for_page(page_q);
`endif
         end

         default: begin
            state_d = S_COVER;
         end
      endcase

      // Status outputs are registered from the next state so they change on
      // the same edge as the state itself.
      game_run_d = (state_d == S_GAME);
      busy_d     = (state_d == S_FADE_OUT) || (state_d == S_FADE_IN);
   end

   // Colour datapath: pick the current page's source and apply brightness.
   always_comb begin
      case (page_q)
         PAGE_COVER: color_sel = color_cover;
         PAGE_GAME:  color_sel = color_game;
         PAGE_OVER:  color_sel = color_over;
         default:    color_sel = '0;
      endcase

`ifdef PAGE_FADE_EN
      color_out_d = '0;
      if (fade_level_q != LEVEL_DARK) begin
         for (int ch = 0; ch < 3; ch++) begin
            color_out_d[8*ch +: 8] = scale_chan(color_sel[8*ch +: 8], fade_level_q);
         end
      end
`else
      color_out_d = color_sel;
`endif
   end

   // State and output registers; reset lands on the full-brightness cover page.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q          <= S_COVER;
         page_q           <= PAGE_COVER;
         target_q         <= PAGE_COVER;
         fade_level_q     <= LEVEL_FULL;
         color_out_q      <= '0;
         game_run_q       <= 1'b0;
         busy_q           <= 1'b0;
         over_cnt_q       <= '0;
         frame_clk_prev_q <= 1'b1;
         start_prev_q     <= 1'b1;
`ifdef PAGE_FADE_EN
         step_cnt_q       <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q          <= state_d;
         page_q           <= page_d;
         target_q         <= target_d;
         fade_level_q     <= fade_level_d;
         color_out_q      <= color_out_d;
         game_run_q       <= game_run_d;
         busy_q           <= busy_d;
         over_cnt_q       <= over_cnt_d;
         frame_clk_prev_q <= frame_clk;
         start_prev_q     <= start_key;
`ifdef PAGE_FADE_EN
         step_cnt_q       <= step_cnt_d;
`endif
      end
   end

   assign color_out  = color_out_q;
   assign page       = page_q;
   assign fade_level = fade_level_q;
   assign game_run   = game_run_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_page_sequencer.sv
// tb_page_sequencer -- randomized bench for page_sequencer. A screen-flow
// model kept as "which page / how many frame ticks into the fade" predicts
// each cycle's outputs; expectations are queued by the driver and checked by
// an independent monitor after every rising clock edge.
module tb_page_sequencer;

   localparam int F = 2;    // frame ticks per fade step
   localparam int G = 300;  // game-over hold, in frame ticks

   logic        Clk       = 1'b0;
   logic        Reset_n   = 1'b1;
   logic        frame_clk = 1'b0;
   logic        start_key = 1'b0;
   logic        game_over = 1'b0;
   logic [23:0] color_cover = '0;
   logic [23:0] color_game  = '0;
   logic [23:0] color_over  = '0;
   logic [23:0] color_out;
   logic [1:0]  page;
   logic [3:0]  fade_level;
   logic        game_run;
   logic        busy;

   page_sequencer #(
      .FRAMES_PER_STEP(F),
      .GAMEOVER_FRAMES(G)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_clk  (frame_clk),
      .start_key  (start_key),
      .game_over  (game_over),
      .color_cover(color_cover),
      .color_game (color_game),
      .color_over (color_over),
      .color_out  (color_out),
      .page       (page),
      .fade_level (fade_level),
      .game_run   (game_run),
      .busy       (busy)
   );

   always #5 Clk = ~Clk;

   // ---------------- scoreboard ----------------
   typedef struct {
      int          page;
      int          level;
      bit          run;
      bit          busy;
      logic [23:0] color;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, want);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_COVER, M_GAME, M_OVER, M_FADE} mode_t;

   mode_t       m_mode       = M_COVER;
   int          m_from       = 0;
   int          m_target     = 0;
   int          m_fticks     = 0;   // frame ticks since the transition began
   int          m_fcyc       = 0;   // clocks since the transition began
   int          m_over_ticks = 0;
   bit          m_fc_prev    = 1'b1;
   bit          m_sk_prev    = 1'b1;
   logic [23:0] tb_cc = 24'h6B83FE;
   logic [23:0] tb_cg = 24'h123456;
   logic [23:0] tb_co = 24'hABCDEF;

   function automatic mode_t mode_of(input int p);
      if (p == 0) return M_COVER;
      if (p == 1) return M_GAME;
      return M_OVER;
   endfunction

   // Brightness as a function of how far into a transition we are.
   function automatic int m_level();
      if (m_mode != M_FADE) return 15;
`ifdef PAGE_FADE_EN
      if (m_fticks / F < 16) return 15 - m_fticks / F;
      return m_fticks / F - 16;
`else
      return 15;
`endif
   endfunction

   function automatic int m_page();
      case (m_mode)
         M_COVER: return 0;
         M_GAME:  return 1;
         M_OVER:  return 2;
         default: begin
`ifdef PAGE_FADE_EN
            return (m_fticks / F >= 16) ? m_target : m_from;
`else
            return (m_fcyc >= 1) ? m_target : m_from;
`endif
         end
      endcase
   endfunction

   function automatic logic [23:0] model_color(input logic [23:0] src, input int lvl);
      logic [23:0] r;
      r = '0;
      if (lvl == 0) return r;
      for (int ch = 0; ch < 3; ch++) begin
         int c;
         c = int'(src[8*ch +: 8]);
         r[8*ch +: 8] = 8'((c * (lvl + 1)) / 16);
      end
      return r;
   endfunction

   task automatic begin_fade(input int from, input int to);
      m_mode       = M_FADE;
      m_from       = from;
      m_target     = to;
      m_fticks     = 0;
      m_fcyc       = 0;
      m_over_ticks = 0;
   endtask

   task automatic model_reset();
      m_mode       = M_COVER;
      m_from       = 0;
      m_target     = 0;
      m_fticks     = 0;
      m_fcyc       = 0;
      m_over_ticks = 0;
      m_fc_prev    = 1'b1;
      m_sk_prev    = 1'b1;
   endtask

   task automatic push_reset_exp();
      exp_t e;
      e.page  = 0;
      e.level = 15;
      e.run   = 1'b0;
      e.busy  = 1'b0;
      e.color = '0;
      exp_q.push_back(e);
   endtask

   // Advance the model across one clock edge with the given inputs.
   task automatic model_step(input bit fc, input bit sk, input bit go);
      bit          tick;
      bit          press;
      int          pg;
      logic [23:0] src;
      exp_t        e;
      tick  = fc && !m_fc_prev;
      press = sk && !m_sk_prev;
      pg    = m_page();
      src   = (pg == 0) ? tb_cc : (pg == 1) ? tb_cg : (pg == 2) ? tb_co : 24'h0;
      e.color = model_color(src, m_level());
      case (m_mode)
         M_COVER: if (press) begin_fade(0, 1);
         M_GAME:  if (go) begin_fade(1, 2);
         M_OVER: begin
            if (press || (tick && m_over_ticks == G - 1)) begin_fade(2, 0);
            else if (tick) m_over_ticks++;
         end
         default: begin
`ifdef PAGE_FADE_EN
            if (tick) m_fticks++;
            if (m_fticks == 32 * F) m_mode = mode_of(m_target);
`else
            m_fcyc++;
            if (m_fcyc == 2) m_mode = mode_of(m_target);
`endif
         end
      endcase
      m_fc_prev = fc;
      m_sk_prev = sk;
      e.page  = m_page();
      e.level = m_level();
      e.run   = (m_mode == M_GAME);
      e.busy  = (m_mode == M_FADE);
      exp_q.push_back(e);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive_cycle(input bit fc, input bit sk, input bit go);
      @(negedge Clk);
      Reset_n     = 1'b1;
      frame_clk   = fc;
      start_key   = sk;
      game_over   = go;
      color_cover = tb_cc;
      color_game  = tb_cg;
      color_over  = tb_co;
      model_step(fc, sk, go);
   endtask

   task automatic step_rand(input int sk_pct, input int go_pct, input bit rnd_col);
      bit fc;
      bit sk;
      bit go;
      fc = 1'($urandom_range(1));
      sk = (int'($urandom_range(99)) < sk_pct);
      go = (int'($urandom_range(99)) < go_pct);
      if (rnd_col) begin
         tb_cc = 24'($urandom);
         tb_cg = 24'($urandom);
         tb_co = 24'($urandom);
      end
      drive_cycle(fc, sk, go);
   endtask

   task automatic run_until_mode(input mode_t want, input int sk_pct, input int go_pct,
                                 input bit rnd_col, input string tag);
      for (int i = 0; i < 6000; i++) begin
         if (m_mode == want) return;
         step_rand(sk_pct, go_pct, rnd_col);
      end
      n_cmp++;
      n_fail++;
      $display("FAIL %s: cycle budget expired before the expected page was reached", tag);
   endtask

   // Assert reset between edges (start key and frame_clk held high) and check
   // the asynchronous effect before the next clock edge.
   task automatic apply_reset(input int cycles);
      @(negedge Clk);
      frame_clk   = 1'b1;
      start_key   = 1'b1;
      game_over   = 1'b0;
      color_cover = tb_cc;
      color_game  = tb_cg;
      color_over  = tb_co;
      Reset_n     = 1'b0;
      #1;
      check("rst_page",       32'(page),       32'd0);
      check("rst_fade_level", 32'(fade_level), 32'd15);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_game_run",   32'(game_run),   32'd0);
      check("rst_color_out",  32'(color_out),  32'd0);
      model_reset();
      push_reset_exp();
      for (int i = 1; i < cycles; i++) begin
         @(negedge Clk);
         push_reset_exp();
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("page",       32'(page),       32'(e.page));
            check("fade_level", 32'(fade_level), 32'(e.level));
            check("game_run",   32'(game_run),   32'(e.run));
            check("busy",       32'(busy),       32'(e.busy));
            check("color_out",  32'(color_out),  32'(e.color));
         end
      end
   end

   // ---------------- directed + randomized sequence ----------------
   initial begin
      int rst_level;
`ifdef PAGE_FADE_EN
      rst_level = 5;
`else
      rst_level = 15;
`endif

      // Reset release with start_key and frame_clk held high: no press, no tick.
      apply_reset(3);
      repeat (4) drive_cycle(1'b1, 1'b1, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);

      // Cover -> game with a colour that exposes the mid-fade scaling;
      // presses and game_over during the fade must be ignored.
      tb_cc = 24'hF7F6D8;
      drive_cycle(1'b0, 1'b1, 1'b0);
      run_until_mode(M_GAME, 20, 20, 1'b0, "cover_to_game");

      // Play with stray presses, then game over -> game-over page.
      repeat (20) step_rand(30, 0, 1'b1);
      run_until_mode(M_OVER, 20, 100, 1'b1, "game_to_over");

      // Hold the game-over page with no key until the timeout returns to cover.
      run_until_mode(M_COVER, 0, 0, 1'b1, "over_timeout");

      // Back to game-over, then press on the very tick that times out.
      drive_cycle(1'b0, 1'b1, 1'b0);
      run_until_mode(M_GAME, 10, 10, 1'b1, "cover_to_game_2");
      drive_cycle(1'b0, 1'b0, 1'b1);
      run_until_mode(M_OVER, 0, 50, 1'b1, "game_to_over_2");
      for (int i = 0; i < 2000; i++) begin
         if (m_over_ticks == G - 1 && !m_fc_prev && !m_sk_prev) break;
         drive_cycle(!m_fc_prev, 1'b0, 1'b0);
      end
      drive_cycle(1'b1, 1'b1, 1'b0);
      run_until_mode(M_COVER, 30, 30, 1'b1, "coincident_exit");

      // Leave the game-over page by key press well before the timeout.
      drive_cycle(1'b0, 1'b1, 1'b0);
      run_until_mode(M_GAME, 10, 10, 1'b1, "cover_to_game_3");
      drive_cycle(1'b0, 1'b0, 1'b1);
      run_until_mode(M_OVER, 0, 50, 1'b1, "game_to_over_3");
      repeat (50) step_rand(0, 0, 1'b1);
      drive_cycle(1'b0, 1'b1, 1'b0);
      run_until_mode(M_COVER, 20, 20, 1'b1, "over_press_exit");

      // Reset in the middle of the fade into the game page.
      drive_cycle(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 2000; i++) begin
         if (m_mode == M_FADE && m_page() == 1 && m_level() == rst_level) break;
         step_rand(10, 10, 1'b1);
      end
      apply_reset(2);
      repeat (3) drive_cycle(1'b1, 1'b1, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);

      // Randomized soak across all pages.
      repeat (1500) step_rand(3, 2, 1'b1);

      repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
      @(posedge Clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
